// File: rtl/nes_joypad_keymap.sv
`default_nettype none
// ============================================================================
// Module   : nes_joypad_keymap
// Purpose  : Maps four USB HID usage codes (one per byte of the keycode PIO
//            word) onto two NES standard-controller button vectors and serves
//            them to the NES CPU through the $4016/$4017 strobe-and-serial-
//            read protocol.
// Ports    : clk, reset      - system clock, synchronous active-high reset
//            keycode[31:0]   - four key slots, 0x00 = empty slot
//            cpu_wr, cpu_rd  - one-cycle write / read strobes
//            cpu_addr        - 0 = $4016 (player 1), 1 = $4017 (player 2)
//            cpu_wdata[7:0]  - write data, bit 0 is the strobe value
//            cpu_rdata[7:0]  - registered read data {OPEN_BUS[7:1], serial bit}
//            buttons_p1/p2   - registered button vectors
//                              {Right,Left,Down,Up,Start,Select,B,A}
// Revision : 1.0 - initial release
// ============================================================================
module nes_joypad_keymap #(
  parameter logic [7:0] OPEN_BUS          = 8'h40,
  parameter bit         SUPPRESS_OPPOSING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] keycode,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic        cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [7:0]  buttons_p1,
  output logic [7:0]  buttons_p2
);

  // Usage codes packed one byte per button, byte i drives button bit i.
  localparam logic [63:0] P1_MAP = {8'h07, 8'h04, 8'h16, 8'h1A,
                                    8'h28, 8'h2C, 8'h0D, 8'h0E};
  localparam logic [63:0] P2_MAP = {8'h4F, 8'h50, 8'h51, 8'h52,
                                    8'h33, 8'h34, 8'h36, 8'h37};

  // True when any slot holds the given code. Mapped codes are never 0x00,
  // so empty slots can never produce a hit.
  function automatic logic key_hit(input logic [31:0] kc, input logic [7:0] code);
    return (kc[7:0] == code) || (kc[15:8] == code) ||
           (kc[23:16] == code) || (kc[31:24] == code);
  endfunction

  function automatic logic [7:0] decode(input logic [31:0] kc, input logic [63:0] map);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      v[i] = key_hit(kc, map[i*8 +: 8]);
    end
    return v;
  endfunction

  // Up(4)+Down(5) or Left(6)+Right(7) held together read as neither held.
  function automatic logic [7:0] suppress(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (SUPPRESS_OPPOSING) begin
      if (v[4] && v[5]) r[5:4] = 2'b00;
      if (v[6] && v[7]) r[7:6] = 2'b00;
    end
    return r;
  endfunction

  logic [31:0] keycode_q,    keycode_d;
  logic [7:0]  buttons_p1_q, buttons_p1_d;
  logic [7:0]  buttons_p2_q, buttons_p2_d;
  logic        strobe_q,     strobe_d;
  logic [7:0]  sr1_q,        sr1_d;
  logic [7:0]  sr2_q,        sr2_d;
  logic [7:0]  cpu_rdata_q,  cpu_rdata_d;
  logic        read_bit;

  // Only bit 0 of the write data is meaningful.
  logic unused_wdata;
  assign unused_wdata = ^cpu_wdata[7:1];

  always_comb begin
    keycode_d    = keycode;
    buttons_p1_d = suppress(decode(keycode_q, P1_MAP));
    buttons_p2_d = suppress(decode(keycode_q, P2_MAP));

    strobe_d = strobe_q;
    if (cpu_wr && !cpu_addr) begin
      strobe_d = cpu_wdata[0];
    end

    sr1_d       = sr1_q;
    sr2_d       = sr2_q;
    cpu_rdata_d = cpu_rdata_q;
    read_bit    = 1'b0;

    // Strobe high: continuous parallel load. Using the pre-edge strobe means a
    // 1->0 write still performs one last reload on its own edge.
    if (strobe_q) begin
      sr1_d = buttons_p1_q;
      sr2_d = buttons_p2_q;
    end

    if (cpu_rd) begin
      if (strobe_q) begin
        // While strobed the pad reports A live, straight from the button
        // register rather than the one-cycle-old shift register copy.
        read_bit = cpu_addr ? buttons_p2_q[0] : buttons_p1_q[0];
      end else begin
        read_bit = cpu_addr ? sr2_q[0] : sr1_q[0];
        // Shifting in ones makes every read past the eighth return 1.
        if (cpu_addr) begin
          sr2_d = {1'b1, sr2_q[7:1]};
        end else begin
          sr1_d = {1'b1, sr1_q[7:1]};
        end
      end
      cpu_rdata_d = {OPEN_BUS[7:1], read_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      keycode_q    <= 32'h0;
      buttons_p1_q <= 8'h00;
      buttons_p2_q <= 8'h00;
      strobe_q     <= 1'b0;
      sr1_q        <= 8'h00;
      sr2_q        <= 8'h00;
      cpu_rdata_q  <= 8'h00;
    end else begin
      keycode_q    <= keycode_d;
      buttons_p1_q <= buttons_p1_d;
      buttons_p2_q <= buttons_p2_d;
      strobe_q     <= strobe_d;
      sr1_q        <= sr1_d;
      sr2_q        <= sr2_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign buttons_p1 = buttons_p1_q;
  assign buttons_p2 = buttons_p2_q;

endmodule
`default_nettype wire

// File: tb/tb_nes_joypad_keymap.sv
`default_nettype none
// ============================================================================
// Module   : tb_nes_joypad_keymap
// Purpose  : Self-checking bench for nes_joypad_keymap. One instance with
//            opposing-direction suppression, one without, sharing all inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nes_joypad_keymap;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] keycode;
  logic        cpu_wr, cpu_rd, cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata, buttons_p1, buttons_p2;
  logic [7:0]  ns_rdata, ns_p1, ns_p2;

  always #5 clk = ~clk;

  nes_joypad_keymap #(.OPEN_BUS(8'h40), .SUPPRESS_OPPOSING(1'b1)) dut (
    .clk(clk), .reset(reset), .keycode(keycode),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .buttons_p1(buttons_p1), .buttons_p2(buttons_p2)
  );

  nes_joypad_keymap #(.OPEN_BUS(8'h40), .SUPPRESS_OPPOSING(1'b0)) dut_ns (
    .clk(clk), .reset(reset), .keycode(keycode),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(ns_rdata), .buttons_p1(ns_p1), .buttons_p2(ns_p2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic a, output logic [7:0] d);
    cpu_rd   = 1'b1;
    cpu_addr = a;
    tick();
    cpu_rd = 1'b0;
    d = cpu_rdata;
  endtask

  task automatic wr(input logic a, input logic [7:0] v);
    cpu_wr    = 1'b1;
    cpu_addr  = a;
    cpu_wdata = v;
    tick();
    cpu_wr = 1'b0;
  endtask

  // ---------------- behavioural reference ----------------
  logic [7:0] map1 [8] = '{8'h0E, 8'h0D, 8'h2C, 8'h28, 8'h1A, 8'h16, 8'h04, 8'h07};
  logic [7:0] map2 [8] = '{8'h37, 8'h36, 8'h34, 8'h33, 8'h52, 8'h51, 8'h50, 8'h4F};

  function automatic logic [7:0] ref_btn(input logic [31:0] kc, input int p, input bit sup);
    logic [7:0] v;
    logic [7:0] code;
    v = 8'h00;
    for (int b = 0; b < 8; b++) begin
      code = (p == 1) ? map2[b] : map1[b];
      for (int s = 0; s < 4; s++) begin
        if (kc[8*s +: 8] == code) v[b] = 1'b1;
      end
    end
    if (sup) begin
      if (v[4] && v[5]) begin v[4] = 1'b0; v[5] = 1'b0; end
      if (v[6] && v[7]) begin v[6] = 1'b0; v[7] = 1'b0; end
    end
    return v;
  endfunction

  function automatic logic [31:0] rand_kc();
    logic [31:0] k;
    logic [7:0]  c;
    int          sel;
    k = 32'h0;
    for (int s = 0; s < 4; s++) begin
      sel = int'($urandom_range(0, 5));
      if (sel == 0)      c = 8'h00;
      else if (sel <= 2) c = map1[$urandom_range(0, 7)];
      else if (sel <= 4) c = map2[$urandom_range(0, 7)];
      else               c = 8'($urandom);
      k[8*s +: 8] = c;
    end
    return k;
  endfunction

  typedef struct {
    logic [31:0] kc;
    logic [7:0]  p1, p2, p1n, p2n;
  } vec_t;

  vec_t vt [9];

  logic [7:0]  d;
  logic [7:0]  pat;
  logic [7:0]  prev_p1, prev_p2;
  // model state for the randomized phase
  logic [7:0]  m_btn [2];
  logic [7:0]  m_btn_ns [2];
  logic [7:0]  m_latch [2];
  int          m_idx [2];
  logic        m_strobe;
  logic [31:0] m_kcq;
  logic [7:0]  m_rdata;
  logic        m_bit;
  int          sel;

  initial begin
    vt[0] = '{32'h0000_280E, 8'h09, 8'h00, 8'h09, 8'h00};
    vt[1] = '{32'h1A16_0407, 8'h00, 8'h00, 8'hF0, 8'h00};
    vt[2] = '{32'h5237_0000, 8'h00, 8'h11, 8'h00, 8'h11};
    vt[3] = '{32'h0000_0000, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[4] = '{32'h0E0E_0E0E, 8'h01, 8'h00, 8'h01, 8'h00};
    vt[5] = '{32'h1A00_0004, 8'h50, 8'h00, 8'h50, 8'h00};
    vt[6] = '{32'h4F50_3637, 8'h00, 8'h03, 8'h00, 8'hC3};
    vt[7] = '{32'h5251_2C0D, 8'h06, 8'h00, 8'h06, 8'h30};
    vt[8] = '{32'hFF99_0000, 8'h00, 8'h00, 8'h00, 8'h00};

    reset = 1'b1; keycode = 32'h0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    cpu_addr = 1'b0; cpu_wdata = 8'h00;
    tick(); tick();
    check8("reset_rdata", cpu_rdata, 8'h00);
    check8("reset_p1", buttons_p1, 8'h00);
    check8("reset_p2", buttons_p2, 8'h00);
    reset = 1'b0;
    tick();

    // Nine reads straight out of reset: sr=0, ones shift in.
    for (int i = 0; i < 9; i++) begin
      rd(1'b0, d);
      check8($sformatf("post_reset_read%0d", i + 1), d, (i < 8) ? 8'h40 : 8'h41);
    end

    // Decode table: one stale check after a single edge, one after two.
    prev_p1 = 8'h00; prev_p2 = 8'h00;
    for (int i = 0; i < 9; i++) begin
      keycode = vt[i].kc;
      tick();
      check8($sformatf("vec%0d_lag_p1", i), buttons_p1, prev_p1);
      check8($sformatf("vec%0d_lag_p2", i), buttons_p2, prev_p2);
      tick();
      check8($sformatf("vec%0d_p1", i), buttons_p1, vt[i].p1);
      check8($sformatf("vec%0d_p2", i), buttons_p2, vt[i].p2);
      check8($sformatf("vec%0d_nosup_p1", i), ns_p1, vt[i].p1n);
      check8($sformatf("vec%0d_nosup_p2", i), ns_p2, vt[i].p2n);
      prev_p1 = vt[i].p1; prev_p2 = vt[i].p2;
    end

    // Player 1 serial read: A + Start.
    keycode = 32'h0000_280E;
    tick(); tick();
    check8("p1_vec", buttons_p1, 8'h09);
    wr(1'b0, 8'h01); wr(1'b0, 8'h00);
    pat = 8'h09;
    for (int i = 0; i < 9; i++) begin
      rd(1'b0, d);
      check8($sformatf("p1_serial%0d", i), d, (i < 8) ? (8'h40 | {7'h0, pat[i]}) : 8'h41);
    end

    // Player 2 interleaved with player 1.
    keycode = 32'h5237_0000;
    tick(); tick();
    check8("p2_vec", buttons_p2, 8'h11);
    wr(1'b0, 8'h01); wr(1'b0, 8'h00);
    pat = 8'h11;
    for (int i = 0; i < 8; i++) begin
      rd(1'b1, d);
      check8($sformatf("p2_serial%0d", i), d, 8'h40 | {7'h0, pat[i]});
      rd(1'b0, d);
      check8($sformatf("p1_interleave%0d", i), d, 8'h40);
    end

    // Strobe held high: reads follow A live, no shifting.
    wr(1'b0, 8'h01);
    keycode = 32'h0000_000E;
    tick(); tick();
    rd(1'b0, d); check8("strobe_A_on", d, 8'h41);
    keycode = 32'h0;
    tick();
    rd(1'b0, d); check8("strobe_A_lag", d, 8'h41);
    rd(1'b0, d); check8("strobe_A_off", d, 8'h40);
    keycode = 32'h0000_000E;
    tick(); tick();
    rd(1'b0, d); check8("strobe_A_on2", d, 8'h41);
    rd(1'b0, d); check8("strobe_noshift", d, 8'h41);
    wr(1'b0, 8'h00);
    rd(1'b0, d); check8("after_strobe_A", d, 8'h41);
    rd(1'b0, d); check8("after_strobe_B", d, 8'h40);

    // Simultaneous read+write, and $4017 writes leaving strobe alone.
    keycode = 32'h0000_280E;
    tick(); tick();
    wr(1'b0, 8'h01); wr(1'b0, 8'h00);
    cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 1'b0; cpu_wdata = 8'h01;
    tick();
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    check8("rdwr_same_cycle", cpu_rdata, 8'h41);
    tick();
    wr(1'b0, 8'h00);
    rd(1'b0, d); check8("reload_wins_A", d, 8'h41);
    wr(1'b1, 8'hFF);
    check8("rdata_hold", cpu_rdata, 8'h41);
    rd(1'b0, d); check8("w4017_ignored", d, 8'h40);

    // Reset in the middle of a read sequence.
    keycode = 32'h0000_000E;
    tick(); tick();
    wr(1'b0, 8'h01); wr(1'b0, 8'h00);
    rd(1'b0, d); check8("mid_read1", d, 8'h41);
    rd(1'b0, d); check8("mid_read2", d, 8'h40);
    rd(1'b0, d); check8("mid_read3", d, 8'h40);
    reset = 1'b1; cpu_rd = 1'b1; keycode = 32'h0;
    tick();
    reset = 1'b0; cpu_rd = 1'b0;
    check8("midrst_rdata", cpu_rdata, 8'h00);
    check8("midrst_p1", buttons_p1, 8'h00);
    check8("midrst_p2", buttons_p2, 8'h00);
    for (int i = 0; i < 9; i++) begin
      rd(1'b0, d);
      check8($sformatf("midrst_read%0d", i + 1), d, (i < 8) ? 8'h40 : 8'h41);
    end

    // Randomized phase against the reference model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int p = 0; p < 2; p++) begin
      m_btn[p] = 8'h00; m_btn_ns[p] = 8'h00; m_latch[p] = 8'h00; m_idx[p] = 0;
    end
    m_strobe = 1'b0; m_kcq = 32'h0; m_rdata = 8'h00;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) keycode = rand_kc();
      cpu_rd    = ($urandom_range(0, 1) == 1);
      cpu_wr    = ($urandom_range(0, 5) == 0);
      cpu_addr  = ($urandom_range(0, 1) == 1);
      cpu_wdata = 8'($urandom);
      sel = cpu_addr ? 1 : 0;
      if (cpu_rd) begin
        if (m_strobe) begin
          m_bit = m_btn[sel][0];
        end else begin
          m_bit = (m_idx[sel] < 8) ? m_latch[sel][m_idx[sel]] : 1'b1;
          if (m_idx[sel] < 8) m_idx[sel]++;
        end
        m_rdata = 8'h40 | {7'h0, m_bit};
      end
      if (m_strobe) begin
        for (int p = 0; p < 2; p++) begin
          m_latch[p] = m_btn[p];
          m_idx[p]   = 0;
        end
      end
      if (cpu_wr && !cpu_addr) m_strobe = cpu_wdata[0];
      for (int p = 0; p < 2; p++) begin
        m_btn[p]    = ref_btn(m_kcq, p, 1'b1);
        m_btn_ns[p] = ref_btn(m_kcq, p, 1'b0);
      end
      m_kcq = keycode;
      tick();
      check8("rand_rdata", cpu_rdata, m_rdata);
      check8("rand_p1", buttons_p1, m_btn[0]);
      check8("rand_p2", buttons_p2, m_btn[1]);
      check8("rand_nosup_p1", ns_p1, m_btn_ns[0]);
      check8("rand_nosup_p2", ns_p2, m_btn_ns[1]);
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
